logreg_sgd_engine: RTL

- Parametrised single-neuron logistic-regression training engine for the FPGA NN datapath.
- Streams labelled samples of N_FEAT unsigned features and computes z = sum(x*w) and yhat = sigmoid(z), using an internal piecewise-linear sigmoid.
- In train mode, applies a per-sample SGD weight update. Successor to the fixed 784x40 batch engine: streaming input, generic sizes, infer mode, saturating arithmetic, host weight access.

---
 rtl/logreg_sgd_engine_if.sv | 25 ++
 rtl/logreg_sgd_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/logreg_sgd_engine_if.sv
// Stream and result bundle for logreg_sgd_engine.
//   s_valid/s_ready/s_data/s_label : feature beat handshake (Q0.8 data, label on beat 0)
//   res_valid/res_yhat/res_z       : per-sample result pulse, sigmoid Q1.8, saturated dot product
// master = sample source / result sink, slave = engine.
interface logreg_sgd_engine_if #(
  parameter int ACC_W = 32
);
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_label;
  logic             res_valid;
  logic [8:0]       res_yhat;
  logic [ACC_W-1:0] res_z;

  modport master (
    output s_valid, s_data, s_label,
    input  s_ready, res_valid, res_yhat, res_z
  );

  modport slave (
    input  s_valid, s_data, s_label,
    output s_ready, res_valid, res_yhat, res_z
  );
endinterface

// File: rtl/logreg_sgd_engine.sv
// Single-neuron logistic-regression engine with per-sample SGD update.
// Streams N_FEAT unsigned features per sample, accumulates z = sum(x*w) with
// sticky saturation, applies a piecewise-linear sigmoid and, in train mode,
// updates every weight by (x*err) >>> LR_SHIFT.
//   clk, rst (sync, active low)
//   start, mode     : run control (mode 0 = train, 1 = infer), sampled in IDLE
//   sif (slave)     : feature stream in, result pulse out
//   wr_en/addr/data : host weight write, IDLE only
//   rd_addr/rd_data : host weight read, registered, 1-cycle latency
//   busy, done      : status; done pulses once per run
module logreg_sgd_engine #(
  parameter int N_FEAT   = 784,
  parameter int N_SAMP   = 40,
  parameter int W_W      = 16,
  parameter int ACC_W    = 32,
  parameter int LR_SHIFT = 8,
  parameter int A_W      = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  logreg_sgd_engine_if.slave sif,
  input  logic           wr_en,
  input  logic [A_W-1:0] wr_addr,
  input  logic [W_W-1:0] wr_data,
  input  logic [A_W-1:0] rd_addr,
  output logic [W_W-1:0] rd_data,
  output logic           busy,
  output logic           done
);
  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int S_W   = $clog2(N_SAMP + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FEAT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
  localparam logic [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, SIG, UPDATE, FIN} state_t;
  state_t state, state_nx;

  logic [W_W-1:0] wmem [N_FEAT];
  logic [7:0]     xbuf [N_FEAT];

  logic [IDX_W-1:0]         feat_idx;
  logic [S_W-1:0]           samp_cnt;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     sat_q;
  logic                     mode_q;
  logic                     label_q;
  logic signed [9:0]        err_q;

  logic                     unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr, rd_addr};

  logic [W_W-1:0] w_cur;
  assign w_cur = wmem[feat_idx];

  // Accumulate path
  logic signed [W_W+8:0] ld_prod;
  logic signed [ACC_W:0] acc_sum;
  logic                  acc_ovf;
  assign ld_prod = $signed({1'b0, sif.s_data}) * $signed(w_cur);
  assign acc_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(ld_prod);
  assign acc_ovf = acc_sum[ACC_W] != acc_sum[ACC_W-1];

  // Piecewise-linear sigmoid on |acc| in Q.12 of the integer part
  logic [ACC_W-1:0] mag, mag_sh;
  logic [10:0]      a;
  logic [8:0]       f, yhat;
  logic signed [9:0] err_c;
  always_comb begin
    mag    = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : acc_q;
    mag_sh = mag >> 12;
    a      = (mag_sh > ACC_W'(2047)) ? 11'd2047 : mag_sh[10:0];
    if (a >= 11'd1280)     f = 9'd256;
    else if (a >= 11'd608) f = 9'(a >> 5) + 9'd216;
    else if (a >= 11'd256) f = 9'(a >> 3) + 9'd160;
    else                   f = 9'(a >> 2) + 9'd128;
    yhat  = acc_q[ACC_W-1] ? 9'd256 - f : f;
    err_c = 10'(yhat) - (label_q ? 10'd256 : 10'd0);
  end

  // Weight update path
  logic signed [18:0]     upd_prod, delta;
  logic signed [W_W+19:0] w_diff;
  logic [W_W-1:0]         w_upd;
  always_comb begin
    upd_prod = $signed({1'b0, xbuf[feat_idx]}) * err_q;
    delta    = upd_prod >>> LR_SHIFT;
    w_diff   = (W_W+20)'($signed(w_cur)) - (W_W+20)'(delta);
    if (w_diff[W_W+19] && !(&w_diff[W_W+18:W_W-1]))      w_upd = W_MIN;
    else if (!w_diff[W_W+19] && (|w_diff[W_W+18:W_W-1])) w_upd = W_MAX;
    else                                                 w_upd = w_diff[W_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    sif.s_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        sif.s_ready = 1'b1;
        if (sif.s_valid && feat_idx == LAST) state_nx = SIG;
      end
      SIG: begin
        if (!mode_q)                              state_nx = UPDATE;
        else if (samp_cnt == S_W'(N_SAMP - 1))    state_nx = FIN;
        else                                      state_nx = LOAD;
      end
      UPDATE: begin
        // samp_cnt was already advanced in SIG, so compare against N_SAMP
        if (feat_idx == LAST)
          state_nx = (samp_cnt == S_W'(N_SAMP)) ? FIN : LOAD;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      feat_idx      <= '0;
      samp_cnt      <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      mode_q        <= 1'b0;
      label_q       <= 1'b0;
      err_q         <= '0;
      sif.res_valid <= 1'b0;
      sif.res_yhat  <= '0;
      sif.res_z     <= '0;
      rd_data       <= '0;
    end else begin
      sif.res_valid <= 1'b0;
      rd_data       <= wmem[rd_addr[IDX_W-1:0]];
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            samp_cnt <= '0;
            feat_idx <= '0;
          end
        end
        LOAD: begin
          if (sif.s_valid) begin
            if (feat_idx == '0) begin
              acc_q   <= ACC_W'(ld_prod);
              label_q <= sif.s_label;
              sat_q   <= 1'b0;
            end else if (!sat_q) begin
              if (acc_ovf) begin
                acc_q <= acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                sat_q <= 1'b1;
              end else begin
                acc_q <= acc_sum[ACC_W-1:0];
              end
            end
            feat_idx <= (feat_idx == LAST) ? '0 : feat_idx + 1'b1;
          end
        end
        SIG: begin
          sif.res_valid <= 1'b1;
          sif.res_yhat  <= yhat;
          sif.res_z     <= acc_q;
          err_q         <= err_c;
          samp_cnt      <= samp_cnt + 1'b1;
          feat_idx      <= '0;
        end
        UPDATE: feat_idx <= (feat_idx == LAST) ? '0 : feat_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Buffers are deliberately outside reset so an aborted run leaves weights intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == IDLE && wr_en && 32'(wr_addr) < 32'(N_FEAT))
        wmem[wr_addr[IDX_W-1:0]] <= wr_data;
      else if (state == UPDATE)
        wmem[feat_idx] <= w_upd;
      if (state == LOAD && sif.s_valid)
        xbuf[feat_idx] <= sif.s_data;
    end
  end
endmodule
